cnn_layer_sequencer: RTL and testbench
======================================

# cnn_layer_sequencer

Top-level scheduler for the CNN engine. Runs a multi-frame job by launching the stage-1 convolution controller once per filter and then the stage-2 controller once per frame, sequencing the two controllers through a start/done pulse handshake. Sits above both stage controllers and drives their start inputs. Optionally guards every wait with a watchdog.

## Interface
Parameters:
- N, 4: filters per frame; stage 1 runs N times per frame.
- FRAMES_W, 8: width of frame count and frame index.
- TIMEOUT, 4096: watchdog limit in cycles per wait; only used with the watchdog compiled in.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  job request, level-sampled in IDLE/ERR.
- num_frames  in  FRAMES_W  frames in the job; latched on accepted start.
- stage1_start  out  1  one-cycle launch pulse to the stage-1 controller.
- stage1_done  in  1  one-cycle completion pulse from stage 1.
- stage2_start  out  1  one-cycle launch pulse to the stage-2 controller.
- stage2_done  in  1  one-cycle completion pulse from stage 2.
- filter_idx  out  max(1,$clog2(N))  current filter; stable from S1_GO through S1_WAIT.
- frame_idx  out  FRAMES_W  current frame, 0-based.
- busy  out  1  high in every state except IDLE, FINISH and ERR.
- done  out  1  one-cycle pulse at job completion.
- error  out  1  sticky watchdog flag.

## Operation
- States: IDLE, S1_GO, S1_WAIT, S2_GO, S2_WAIT, FINISH, ERR.
- IDLE:
  - start=1 with num_frames≠0: latch num_frames, clear frame_idx and filter_idx, go to S1_GO.
  - start=1 with num_frames=0: go to FINISH.
- S1_GO: stage1_start=1 for this cycle only; go to S1_WAIT.
- S1_WAIT: on stage1_done:
  - filter_idx<N-1: increment filter_idx, go to S1_GO.
  - Otherwise: go to S2_GO.
- S2_GO: stage2_start=1 for one cycle; go to S2_WAIT.
- S2_WAIT: on stage2_done:
  - Last frame (frame_idx==latched-1): go to FINISH.
  - Otherwise: increment frame_idx, clear filter_idx, go to S1_GO.
- FINISH: done=1 for one cycle; go to IDLE.
- Done inputs are honoured only in the matching WAIT state. Pulses in any other state, including the GO cycle, are ignored.
- start while busy is ignored. num_frames changes after latching have no effect.
- Simultaneous stage1_done and stage2_done: only the one matching the current state is acted on.
- Reset (any time, including mid-job):
  - State returns to IDLE immediately.
  - All outputs go to 0, including error.
  - Counters clear. No done pulse is produced.

## Timing
- Accepted start in cycle t: stage1_start in cycle t+1.
- Done pulse in WAIT at cycle t: next GO state, or FINISH, in cycle t+1.
- Minimum job, num_frames=0: start at t, done at t+1, IDLE at t+2.
- Counter widths: filter_idx wraps only via explicit clear, never by overflow. frame_idx never exceeds num_frames-1.

## Configuration
- Macro SEQ_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entry to S1_WAIT/S2_WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without the awaited done, the next state is ERR and error=1 (sticky).
  - In ERR, busy=0 and done is not pulsed.
  - start in ERR clears error and begins a new job exactly as from IDLE.
  - A done arriving in the same cycle as the timeout wins; no error is raised.
- Undefined: no counter, ERR unreachable, error tied 0, TIMEOUT ignored.

## Structure
- Shared package cnn_seq_pkg holds:
  - State encoding localparams, 3-bit: IDLE=0, S1_GO=1, S1_WAIT=2, S2_GO=3, S2_WAIT=4, FINISH=5, ERR=6.
  - Default TIMEOUT constant.
- One sub-module, seq_watchdog, instantiated only under SEQ_WATCHDOG_EN.
  - Inputs: clk, rst_n, clr, en.
  - Output: expired.

## Test plan
- N=2, num_frames=1; start at cycle 0; stage1_done at cycles 2 and 4; stage2_done at cycle 6. Required:
  - stage1_start at cycles 1 and 3, with filter_idx 0 then 1.
  - stage2_start at cycle 5.
  - done at cycle 7; busy low at cycle 8.
- N=4, num_frames=3, done returned 3 cycles after each launch: exactly 12 stage1_start and 3 stage2_start pulses; frame_idx sequence 0,1,2; one done pulse.
- num_frames=0: done exactly one cycle after start; no stage launches.
- Spurious pulses: stage2_done during S1_WAIT, and stage1_done during an S1_GO cycle. Both are ignored; state and indices are unchanged.
- Reset: rst_n low in mid S2_WAIT of frame 1. All outputs 0 asynchronously. After release, a fresh start restarts from frame 0, filter 0.
- SEQ_WATCHDOG_EN, TIMEOUT=16: stage1_done withheld.
  - error rises 16 cycles after S1_WAIT entry, with busy=0.
  - A following start clears error and relaunches stage1_start one cycle later.

Source files
------------

// File: rtl/cnn_seq_pkg.sv
// cnn_seq_pkg: state encoding and default watchdog limit shared by the layer sequencer.
package cnn_seq_pkg;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_S1_GO   = 3'd1;
    localparam logic [2:0] ST_S1_WAIT = 3'd2;
    localparam logic [2:0] ST_S2_GO   = 3'd3;
    localparam logic [2:0] ST_S2_WAIT = 3'd4;
    localparam logic [2:0] ST_FINISH  = 3'd5;
    localparam logic [2:0] ST_ERR     = 3'd6;
    localparam int SEQ_TIMEOUT = 4096;
endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: per-wait cycle counter, flags expiry after TIMEOUT-1 waiting cycles.
// Only built when SEQ_WATCHDOG_EN is defined.
`ifdef SEQ_WATCHDOG_EN
module seq_watchdog import cnn_seq_pkg::*; #(
    parameter int TIMEOUT = SEQ_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && cnt != LIMIT) cnt <= cnt + W'(1);
    end
    assign expired = en && cnt == LIMIT;
endmodule
`endif

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: launches stage 1 once per filter, then stage 2 once per frame, for a multi-frame job.
// Define SEQ_WATCHDOG_EN to guard every wait with seq_watchdog and enable the ERR state.
module cnn_layer_sequencer import cnn_seq_pkg::*; #(
    parameter int N        = 4,
    parameter int FRAMES_W = 8,
    parameter int TIMEOUT  = SEQ_TIMEOUT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [FRAMES_W-1:0]                   num_frames,
    output logic                                  stage1_start,
    input  logic                                  stage1_done,
    output logic                                  stage2_start,
    input  logic                                  stage2_done,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0]    filter_idx,
    output logic [FRAMES_W-1:0]                   frame_idx,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error
);
    localparam int FW = N > 1 ? $clog2(N) : 1;
    localparam logic [FW-1:0] LAST_FILTER = FW'(N - 1);
    logic [2:0] state, state_nx;
    logic [FRAMES_W-1:0] frames, last_frame;
    logic accept, expired;
    assign accept     = start && (state == ST_IDLE || state == ST_ERR);
    assign last_frame = frames - FRAMES_W'(1);
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_ERR: if (start) state_nx = num_frames != '0 ? ST_S1_GO : ST_FINISH;
            ST_S1_GO:   state_nx = ST_S1_WAIT;
            ST_S1_WAIT: state_nx = stage1_done ? (filter_idx == LAST_FILTER ? ST_S2_GO : ST_S1_GO)
                                 : expired ? ST_ERR : state;
            ST_S2_GO:   state_nx = ST_S2_WAIT;
            ST_S2_WAIT: state_nx = stage2_done ? (frame_idx == last_frame ? ST_FINISH : ST_S1_GO)
                                 : expired ? ST_ERR : state;
            default:    state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            frames     <= '0;
            filter_idx <= '0;
            frame_idx  <= '0;
        end else begin
            state <= state_nx;
            if (accept && num_frames != '0) begin
                frames     <= num_frames;
                filter_idx <= '0;
                frame_idx  <= '0;
            end else if (state == ST_S1_WAIT && stage1_done && filter_idx != LAST_FILTER) begin
                filter_idx <= filter_idx + FW'(1);
            end else if (state == ST_S2_WAIT && stage2_done && frame_idx != last_frame) begin
                frame_idx  <= frame_idx + FRAMES_W'(1);
                filter_idx <= '0;
            end
        end
    end
    assign stage1_start = state == ST_S1_GO;
    assign stage2_start = state == ST_S2_GO;
    assign done         = state == ST_FINISH;
    assign busy         = !(state == ST_IDLE || state == ST_FINISH || state == ST_ERR);
`ifdef SEQ_WATCHDOG_EN
    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (stage1_start || stage2_start),
        .en      (state == ST_S1_WAIT || state == ST_S2_WAIT),
        .expired (expired)
    );
    assign error = state == ST_ERR;
`else
    localparam int unused_timeout = TIMEOUT;
    assign expired = 1'b0;
    assign error   = 1'b0;
`endif
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: table-driven plus hand-written sequences for the layer sequencer.
module tb_cnn_layer_sequencer;
`ifdef SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_start = 0, a_d1 = 0, a_d2 = 0, a_s1s, a_s2s, a_busy, a_done, a_err;
    logic [7:0] a_nf = 0, a_fr;
    logic [0:0] a_fi;
    logic       b_start = 0, b_d1 = 0, b_d2 = 0, b_s1s, b_s2s, b_busy, b_done, b_err;
    logic [7:0] b_nf = 0, b_fr;
    logic [1:0] b_fi;

    cnn_layer_sequencer #(.N(2), .FRAMES_W(8), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .num_frames(a_nf),
        .stage1_start(a_s1s), .stage1_done(a_d1), .stage2_start(a_s2s), .stage2_done(a_d2),
        .filter_idx(a_fi), .frame_idx(a_fr), .busy(a_busy), .done(a_done), .error(a_err));
    cnn_layer_sequencer #(.N(4), .FRAMES_W(8), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .num_frames(b_nf),
        .stage1_start(b_s1s), .stage1_done(b_d1), .stage2_start(b_s2s), .stage2_done(b_d2),
        .filter_idx(b_fi), .frame_idx(b_fr), .busy(b_busy), .done(b_done), .error(b_err));

    typedef struct {
        logic st; logic [7:0] nf; logic d1, d2;
        logic s1s, s2s, fi; logic [7:0] fr; logic busy, done;
    } vec_t;

    int errors = 0, checks = 0;

    function automatic vec_t mk(logic st, logic [7:0] nf, logic d1, logic d2,
                                logic s1s, logic s2s, logic fi, logic [7:0] fr, logic busy, logic done);
        vec_t v;
        v.st = st; v.nf = nf; v.d1 = d1; v.d2 = d2;
        v.s1s = s1s; v.s2s = s2s; v.fi = fi; v.fr = fr; v.busy = busy; v.done = done;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        vec_t tbl[28];
        int t1, t2, n1, n2, nd, fi_exp;
        // N=2: one frame, then zero-frame job, then spurious pulses through two frames
        tbl[0]  = mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0,  1, 0, 0, 0, 1, 0);
        tbl[2]  = mk(0, 1, 1, 0,  0, 0, 0, 0, 1, 0);
        tbl[3]  = mk(0, 1, 0, 0,  1, 0, 1, 0, 1, 0);
        tbl[4]  = mk(0, 1, 1, 0,  0, 0, 1, 0, 1, 0);
        tbl[5]  = mk(0, 1, 0, 0,  0, 1, 1, 0, 1, 0);
        tbl[6]  = mk(0, 1, 0, 1,  0, 0, 1, 0, 1, 0);
        tbl[7]  = mk(0, 1, 0, 0,  0, 0, 1, 0, 0, 1);
        tbl[8]  = mk(0, 1, 0, 0,  0, 0, 1, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0,  0, 0, 1, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        tbl[12] = mk(1, 2, 0, 0,  0, 0, 1, 0, 0, 0);
        tbl[13] = mk(0, 2, 1, 0,  1, 0, 0, 0, 1, 0);
        tbl[14] = mk(0, 2, 0, 1,  0, 0, 0, 0, 1, 0);
        tbl[15] = mk(1, 5, 0, 0,  0, 0, 0, 0, 1, 0);
        tbl[16] = mk(0, 5, 1, 1,  0, 0, 0, 0, 1, 0);
        tbl[17] = mk(0, 5, 0, 0,  1, 0, 1, 0, 1, 0);
        tbl[18] = mk(0, 5, 1, 0,  0, 0, 1, 0, 1, 0);
        tbl[19] = mk(0, 5, 0, 0,  0, 1, 1, 0, 1, 0);
        tbl[20] = mk(0, 5, 1, 0,  0, 0, 1, 0, 1, 0);
        tbl[21] = mk(0, 5, 0, 1,  0, 0, 1, 0, 1, 0);
        tbl[22] = mk(0, 5, 0, 0,  1, 0, 0, 1, 1, 0);
        tbl[23] = mk(0, 5, 1, 0,  0, 0, 0, 1, 1, 0);
        tbl[24] = mk(0, 5, 0, 0,  1, 0, 1, 1, 1, 0);
        tbl[25] = mk(0, 5, 1, 0,  0, 0, 1, 1, 1, 0);
        tbl[26] = mk(0, 5, 0, 0,  0, 1, 1, 1, 1, 0);
        tbl[27] = mk(0, 5, 0, 0,  0, 0, 1, 1, 1, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            a_start = tbl[i].st; a_nf = tbl[i].nf; a_d1 = tbl[i].d1; a_d2 = tbl[i].d2;
            #1;
            check($sformatf("row%0d", i), {a_s1s, a_s2s, a_fi, a_fr, a_busy, a_done, a_err},
                  {tbl[i].s1s, tbl[i].s2s, tbl[i].fi, tbl[i].fr, tbl[i].busy, tbl[i].done, 1'b0});
        end
        a_start = 0; a_d1 = 0; a_d2 = 0;

        // asynchronous reset in the middle of S2_WAIT of frame 1
        #2 rst_n = 1'b0;
        #1;
        check("reset_a", {a_s1s, a_s2s, a_fi, a_fr, a_busy, a_done, a_err}, 0);
        check("reset_b", {b_s1s, b_s2s, b_fi, b_fr, b_busy, b_done, b_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_start = 1; a_nf = 1;
        @(negedge clk);
        a_start = 0;
        #1;
        check("restart", {a_s1s, a_fi, a_fr, a_busy, a_err}, {1'b1, 1'b0, 8'd0, 1'b1, 1'b0});

        // stage1_done withheld: watchdog trips after 16 waiting cycles when compiled in
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); #1;
            check($sformatf("wd_wait%0d", k), {a_busy, a_err}, 2'b10);
        end
        @(negedge clk); #1;
        check("wd_err", {a_busy, a_err, a_done}, WD ? 3'b010 : 3'b100);
        a_start = 1; a_nf = 1;
        @(negedge clk);
        a_start = 0;
        #1;
        check("wd_relaunch", {a_s1s, a_err, a_busy}, WD ? 3'b101 : 3'b001);

        // N=4, 3 frames, every done returned 3 cycles after its launch
        @(negedge clk);
        b_start = 1; b_nf = 3;
        @(negedge clk);
        b_start = 0;
        t1 = 0; t2 = 0; n1 = 0; n2 = 0; nd = 0; fi_exp = 0;
        for (int c = 0; c < 400 && nd == 0; c++) begin
            b_d1 = (t1 == 1); b_d2 = (t2 == 1);
            if (t1 > 0) t1--;
            if (t2 > 0) t2--;
            #1;
            if (b_s1s) begin
                check($sformatf("b_filter%0d", n1), b_fi, fi_exp);
                fi_exp = (fi_exp + 1) % 4; n1++; t1 = 3;
            end
            if (b_s2s) begin
                check($sformatf("b_frame%0d", n2), b_fr, n2);
                n2++; t2 = 3;
            end
            if (b_done) nd++;
            @(negedge clk);
        end
        b_d1 = 0; b_d2 = 0;
        check("b_s1_count", n1, 12);
        check("b_s2_count", n2, 3);
        check("b_done_count", nd, 1);
        #1;
        check("b_idle_after", {b_busy, b_done, b_err}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
